// File: rtl/jtag_ocimem_monitor.sv
// Sysclk-side OCI memory monitor: turns decoded JTAG debug commands into
// single-word Avalon-MM reads/writes and reports data, ready and error back.
module jtag_ocimem_monitor #(
  parameter int ADDR_W         = 10,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic [ADDR_W+1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest,
  output logic [31:0]       MonDReg,
  output logic [ADDR_W-1:0] MonAReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  // Handshake: a strobe (avm_read/avm_write) is raised with stable address
  // and data and is held until the cycle it is sampled with waitrequest=0.
  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2} state_t;

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  areg_q, areg_d;
  logic [31:0]        dreg_q, dreg_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               read_q, read_d;
  logic               write_q, write_d;
  logic               ready_q, ready_d;
  logic               error_q, error_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               any_take;

  assign any_take = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;

  always_comb begin
    state_d = state_q;
    areg_d  = areg_q;
    dreg_d  = dreg_q;
    wdata_d = wdata_q;
    read_d  = read_q;
    write_d = write_q;
    ready_d = ready_q;
    error_d = error_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (take_action_ocimem_a) begin
          areg_d = jdo[ADDR_W+16:17];
          if (jdo[35]) error_d = 1'b0;
          if (jdo[34]) begin
            state_d = RD;
            read_d  = 1'b1;
            ready_d = 1'b0;
            cnt_d   = '0;
          end
        end else if (take_no_action_ocimem_a) begin
          state_d = RD;
          read_d  = 1'b1;
          ready_d = 1'b0;
          cnt_d   = '0;
        end else if (take_action_ocimem_b) begin
          state_d = WR;
          wdata_d = jdo[34:3];
          dreg_d  = jdo[34:3];
          write_d = 1'b1;
          ready_d = 1'b0;
          cnt_d   = '0;
        end
      end
      RD, WR: begin
        // Commands arriving mid-access are dropped and flagged as overrun.
        if (any_take) error_d = 1'b1;
        if (!avm_waitrequest) begin
          if (state_q == RD) dreg_d = avm_readdata;
          read_d  = 1'b0;
          write_d = 1'b0;
          ready_d = 1'b1;
          areg_d  = areg_q + 1'b1;
          state_d = IDLE;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          ready_d = 1'b1;
          error_d = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      areg_q  <= '0;
      dreg_q  <= '0;
      wdata_q <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      ready_q <= 1'b1;
      error_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      areg_q  <= areg_d;
      dreg_q  <= dreg_d;
      wdata_q <= wdata_d;
      read_q  <= read_d;
      write_q <= write_d;
      ready_q <= ready_d;
      error_q <= error_d;
      cnt_q   <= cnt_d;
    end
  end

  assign avm_address    = {areg_q, 2'b00};
  assign avm_read       = read_q;
  assign avm_write      = write_q;
  assign avm_writedata  = wdata_q;
  assign avm_byteenable = 4'hF;
  assign MonDReg        = dreg_q;
  assign MonAReg        = areg_q;
  assign monitor_ready  = ready_q;
  assign monitor_error  = error_q;

  logic unused_jdo;
  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

endmodule

// File: doc/jtag_ocimem_monitor.md
Name: jtag_ocimem_monitor

Overview:
- Sysclk-domain consumer of the JTAG debug module's decoded command strobes (take_action_ocimem_a/b, take_no_action_ocimem_a) and the 38-bit jdo shift data.
- Turns those commands into single-word Avalon-MM master accesses on the debug/system bus.
- Produces MonDReg, monitor_ready and monitor_error, which return to the JTAG debug module for readback by the host.

Parameters:
- ADDR_W, 10, word-address width of MonAReg; avm_address is ADDR_W+2 bits wide (byte address).
- TIMEOUT_CYCLES, 256, waitrequest cycles before an access is aborted; 0 disables the timeout.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  synchronous active-low reset.
- jdo  in  38  JTAG shift data, stable while any take_* strobe is high.
- take_action_ocimem_a  in  1  1-cycle strobe: address/control command.
- take_no_action_ocimem_a  in  1  1-cycle strobe: read at current address.
- take_action_ocimem_b  in  1  1-cycle strobe: write jdo[34:3] at current address.
- avm_address  out  ADDR_W+2  byte address, {MonAReg, 2'b00}.
- avm_read  out  1  read strobe, held until accepted.
- avm_write  out  1  write strobe, held until accepted.
- avm_writedata  out  32  write data.
- avm_byteenable  out  4  constant 4'hF.
- avm_readdata  in  32  valid in the cycle avm_read=1 and avm_waitrequest=0.
- avm_waitrequest  in  1  slave stall.
- MonDReg  out  32  last read data, or last write data.
- MonAReg  out  ADDR_W  current word address.
- monitor_ready  out  1  high when idle and the last access is complete.
- monitor_error  out  1  sticky error flag.

Behaviour:
- Reset (reset_n=0 at an edge): state=IDLE. MonDReg=0, MonAReg=0, avm_read=0, avm_write=0, avm_writedata=0, monitor_ready=1, monitor_error=0, timeout counter=0.
- Reset is honoured mid-access: the strobes drop at that edge and no completion is recorded.
- FSM states: IDLE, RD, WR. All outputs are registered.
- Commands in IDLE; priority a > no_action_a > b; lower-priority strobes in the same cycle are dropped without error.
- take_action_ocimem_a:
  - MonAReg <= jdo[ADDR_W+16:17].
  - If jdo[35]=1: monitor_error <= 0.
  - If jdo[34]=1: go to RD at the new address, avm_read <= 1, monitor_ready <= 0. Otherwise stay in IDLE.
- take_no_action_ocimem_a: go to RD at MonAReg, avm_read <= 1, monitor_ready <= 0.
- take_action_ocimem_b: avm_writedata <= jdo[34:3], MonDReg <= jdo[34:3], avm_write <= 1, monitor_ready <= 0, go to WR.
- RD/WR completion, at the edge where the strobe=1 and waitrequest=0:
  - RD captures MonDReg <= avm_readdata.
  - Strobe <= 0, monitor_ready <= 1, MonAReg <= MonAReg+1 (wraps modulo 2^ADDR_W), back to IDLE.
  - Strobe is visible one cycle after the command edge; zero-wait slave gives monitor_ready high 2 cycles after the command edge.
- Timeout:
  - Counter clears on entry to RD/WR and increments each cycle waitrequest=1.
  - At the edge where the counter equals TIMEOUT_CYCLES-1 and waitrequest=1: abort.
  - Abort: strobe <= 0, monitor_error <= 1, monitor_ready <= 1, MonDReg and MonAReg unchanged, back to IDLE.
- Any take_* strobe while in RD/WR: ignored; monitor_error <= 1 (overrun).
- monitor_error is cleared only by reset or take_action_ocimem_a with jdo[35]=1. Clear and a concurrent overrun/timeout at the same edge: set wins.
- Address and data are stable while a strobe is held.

Test Plan:
- Reset, then a=1 with jdo address field=10'h005, jdo[34]=1, slave returns 32'hDEADBEEF with 0 wait -> avm_address=12'h014; MonDReg=DEADBEEF; MonAReg=6; ready high 2 cycles after the strobe edge.
- b with jdo[34:3]=32'h12345678, waitrequest high 3 cycles -> avm_write held 4 cycles with writedata stable; then MonAReg+1, MonDReg=12345678, ready=1.
- MonAReg=10'h3FF, no_action_a read completes -> MonAReg wraps to 0.
- TIMEOUT_CYCLES=4, waitrequest stuck high -> abort after 4 stalled cycles; error=1, ready=1, MonAReg unchanged. Then a with jdo[35]=1, jdo[34]=0 -> error=0.
- Strobe b during an RD stall -> error=1, read still completes; a and b in the same idle cycle -> only the address load/read occurs, no write.
- reset_n=0 mid-RD with waitrequest high -> next cycle avm_read=0, ready=1, MonDReg=0.
